// File: rtl/clk_div_prog.sv
// Programmable glitch-free clock divider: registered divided clock, tick, pending divisor.
// Define CLKDIV_PERIOD_CNT_EN to add the 16-bit completed-period counter port.
module clk_div_prog #(
  parameter int WIDTH       = 16,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  output logic             clk_out,
  output logic             tick,
  output logic             pend
`ifdef CLKDIV_PERIOD_CNT_EN
  ,
  output logic [15:0]      period_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    SWITCH = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] MIN_DIV = WIDTH'(2);
  localparam logic [WIDTH-1:0] RST_DIV = WIDTH'(DEFAULT_DIV);

  state_t           state;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] div_cur;
  logic [WIDTH-1:0] div_pend;
  logic [WIDTH-1:0] de;
  logic [WIDTH-1:0] de_m1;
  logic [WIDTH-1:0] half;
  logic [WIDTH-1:0] cnt_nxt;
  logic             wrap;

  // 0 and 1 are clamped so the output always toggles
  assign de      = (div_cur < MIN_DIV) ? MIN_DIV : div_cur;
  assign de_m1   = de - WIDTH'(1);
  assign half    = (de >> 1) + WIDTH'(de[0]);
  assign wrap    = (cnt == de_m1);
  assign cnt_nxt = wrap ? '0 : cnt + WIDTH'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      div_cur  <= RST_DIV;
      div_pend <= '0;
      pend     <= 1'b0;
      clk_out  <= 1'b0;
      tick     <= 1'b0;
    end else begin
      if (div_load) begin
        div_pend <= div_in;
        pend     <= 1'b1;
      end
      if (!en) begin
        state <= IDLE;
        tick  <= 1'b0;
      end else begin
        cnt     <= cnt_nxt;
        clk_out <= (cnt_nxt < half);
        tick    <= (cnt_nxt == de_m1);
        // swap only at the period boundary; a load on
        // this same edge stays queued for the next one
        if (wrap && pend) begin
          div_cur <= div_pend;
          if (!div_load) pend <= 1'b0;
          state <= SWITCH;
        end else begin
          state <= RUN;
        end
      end
    end
  end

`ifdef CLKDIV_PERIOD_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_cnt <= '0;
    end else if (en && (cnt_nxt == de_m1)) begin
      period_cnt <= period_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_clk_div_prog.sv
// Scoreboard bench for clk_div_prog: per-cycle expected outputs from a behavioural model.
// Model follows the divider description; period_cnt checked when CLKDIV_PERIOD_CNT_EN is set.
module tb_clk_div_prog;

  logic        clk;
  logic        rst;
  logic        en;
  logic [15:0] div_in;
  logic        div_load;
  logic        clk_out;
  logic        tick;
  logic        pend;
`ifdef CLKDIV_PERIOD_CNT_EN
  logic [15:0] period_cnt;
`endif

  clk_div_prog #(.WIDTH(16), .DEFAULT_DIV(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .div_in   (div_in),
    .div_load (div_load),
    .clk_out  (clk_out),
    .tick     (tick),
    .pend     (pend)
`ifdef CLKDIV_PERIOD_CNT_EN
    ,
    .period_cnt (period_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int m_cnt;
  int m_cur;
  int m_pv;
  int m_pc;
  bit m_pend;
  bit m_clk;
  bit m_tick;

  typedef struct {
    bit clk_o;
    bit tick_o;
    bit pend_o;
    int pc;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int eff(input int d);
    return (d < 2) ? 2 : d;
  endfunction

  function void model_reset();
    m_cnt  = 0;
    m_cur  = 4;
    m_pv   = 0;
    m_pc   = 0;
    m_pend = 0;
    m_clk  = 0;
    m_tick = 0;
  endfunction

  function void model_edge(input bit e, input bit l, input int d);
    int de;
    int hi;
    int nc;
    bit np;
    de = eff(m_cur);
    hi = (de + 1) / 2;
    np = m_pend;
    if (l) np = 1;
    if (e) begin
      nc = (m_cnt == de - 1) ? 0 : m_cnt + 1;
      if (m_cnt == de - 1 && m_pend) begin
        m_cur = m_pv;
        if (!l) np = 0;
      end
      m_clk  = (nc < hi);
      m_tick = (nc == de - 1);
      if (m_tick) m_pc = (m_pc + 1) % 65536;
      m_cnt  = nc;
    end else begin
      m_tick = 0;
    end
    if (l) m_pv = d;
    m_pend = np;
  endfunction

  task automatic step(input bit e, input bit l, input int d);
    exp_t x;
    en       = e;
    div_load = l;
    div_in   = 16'(d);
    model_edge(e, l, d);
    sb.push_back('{m_clk, m_tick, m_pend, m_pc});
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk("clk_out", int'(clk_out), int'(x.clk_o));
    chk("tick", int'(tick), int'(x.tick_o));
    chk("pend", int'(pend), int'(x.pend_o));
`ifdef CLKDIV_PERIOD_CNT_EN
    chk("period_cnt", int'(period_cnt), x.pc);
`endif
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0);
  endtask

  task automatic wait_cnt(input int c, input int d);
    int n;
    n = 0;
    while (!(m_cnt == c && m_cur == d) && n < 200) begin
      step(1, 0, 0);
      n++;
    end
    chk("wait_cnt_bound", int'(n < 200), 1);
  endtask

  task automatic wait_wrap();
    int n;
    n = 0;
    while (m_cnt != eff(m_cur) - 1 && n < 200) begin
      step(1, 0, 0);
      n++;
    end
    chk("wait_wrap_bound", int'(n < 200), 1);
  endtask

  task automatic async_reset();
    rst = 1'b1;
    #2;
    model_reset();
    sb.delete();
    chk("rst_clk_out", int'(clk_out), 0);
    chk("rst_tick", int'(tick), 0);
    chk("rst_pend", int'(pend), 0);
`ifdef CLKDIV_PERIOD_CNT_EN
    chk("rst_period_cnt", int'(period_cnt), 0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  logic [3:0] pat;
  int hi_len;
  int lo_len;

  initial begin
    rst      = 1'b1;
    en       = 1'b0;
    div_load = 1'b0;
    div_in   = '0;
    model_reset();
    #3;
    async_reset();

    // default divisor 4: first edge starts high, then 1,1,0,0
    step(1, 0, 0);
    chk("first_high", int'(clk_out), 1);
    run(2);
    pat = '0;
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0);
      pat = {pat[2:0], clk_out};
    end
    chk("d4_pattern", int'(pat), 4'b1100);
    run(5);

    // mid-period load of 5
    step(1, 1, 5);
    chk("pend_after_load", int'(pend), 1);
    wait_cnt(0, 5);
    hi_len = 0;
    lo_len = 0;
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0);
      if (clk_out) hi_len++;
      else lo_len++;
    end
    chk("d5_high", hi_len, 3);
    chk("d5_low", lo_len, 2);
    run(6);

    // clamped divisors
    step(1, 1, 0);
    run(12);
    step(1, 1, 1);
    run(12);

    // freeze at cnt=2 with D=6
    step(1, 1, 6);
    wait_cnt(2, 6);
    for (int i = 0; i < 7; i++) step(0, 0, 0);
    run(12);

    // two loads in one period, only the last one lands
    step(1, 1, 8);
    run(1);
    step(1, 1, 3);
    run(20);

    // load on the wrap cycle with another already pending
    step(1, 1, 7);
    wait_wrap();
    step(1, 1, 2);
    run(20);

    // pending while disabled, applied only after re-enable
    step(0, 1, 9);
    for (int i = 0; i < 5; i++) step(0, 0, 0);
    run(24);

    // reset mid-period with a divisor pending
    step(1, 1, 5);
    wait_cnt(2, 5);
    step(1, 1, 11);
    async_reset();
    run(12);

    for (int i = 0; i < 300; i++) begin
      step(bit'($urandom_range(0, 7) != 0),
           bit'($urandom_range(0, 9) == 0),
           int'($urandom_range(0, 9)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got 1 exp 0");
    $fatal(1, "timeout");
  end

endmodule
